pipe_hazard_ctrl: RTL

// Central stall/flush sequencer for the 5-stage pipeline. Detects load-use hazards, taken

---
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the pipeline in, register enables/flushes and debug state out.
// The master side is the pipeline datapath, and the slave side is the sequencer.
interface pipe_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] ifid_rs_i;
   logic [REG_W-1:0] ifid_rt_i;
   logic             idex_memread_i;
   logic [REG_W-1:0] idex_rt_i;
   logic             jump_i;
   logic             branch_taken_i;
   logic             dmem_busy_i;
   logic             pc_we_o;
   logic             ifid_we_o;
   logic             idex_we_o;
   logic             exmem_we_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             exmem_flush_o;
   logic             memwb_flush_o;
   logic [1:0]       state_o;
   logic             timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i, jump_i, branch_taken_i, dmem_busy_i,
      input  pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o,
             exmem_flush_o, memwb_flush_o, state_o, timeout_o, stall_cnt_o, flush_cnt_o
   );
   modport slave (
      input  ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i, jump_i, branch_taken_i, dmem_busy_i,
      output pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, ifid_flush_o, idex_flush_o,
             exmem_flush_o, memwb_flush_o, state_o, timeout_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Enables and flushes are combinational from state and inputs.
// State and the saturating debug counters update on clk_i.
module pipe_hazard_ctrl #(
   parameter int REG_W    = 5,
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   pipe_hazard_ctrl_if.slave    bus
);
   typedef enum logic [1:0] {S_RUN = 2'd0, S_LU_STALL = 2'd1, S_MEM_WAIT = 2'd2, S_ERR = 2'd3} state_t;
   typedef enum logic [2:0] {A_NONE, A_FREEZE, A_BRANCH, A_LU, A_JUMP} act_t;

   localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

   state_t           state_q, state_d;
   logic [7:0]       wait_q, wait_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             lu_hit;
   act_t             act;

   assign lu_hit = bus.idex_memread_i && (bus.idex_rt_i != '0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

   // Shared decision: both next-state and output logic key off the same action.
   always_comb begin
      act = A_NONE;
      unique case (state_q)
         S_RUN, S_LU_STALL, S_MEM_WAIT: begin
            if (bus.dmem_busy_i)                      act = A_FREEZE;
            else if (bus.branch_taken_i)              act = A_BRANCH;
            else if (lu_hit && state_q != S_LU_STALL) act = A_LU;
            else if (bus.jump_i)                      act = A_JUMP;
         end
         default: act = A_FREEZE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      stall_d   = stall_q;
      flush_d   = flush_q;
      if (state_q != S_ERR) begin
         unique case (act)
            A_FREEZE: begin
               if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
               if (state_q != S_MEM_WAIT) begin
                  state_d = S_MEM_WAIT;
                  wait_d  = 8'd1;
               end else if (wait_q == WAIT_MAX_C) begin
                  state_d   = S_ERR;
                  timeout_d = 1'b1;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end
            A_LU: begin
               if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
               state_d = S_LU_STALL;
               wait_d  = '0;
            end
            A_BRANCH, A_JUMP: begin
               if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
               state_d = S_RUN;
               wait_d  = '0;
            end
            default: begin
               state_d = S_RUN;
               wait_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.pc_we_o       = 1'b1;
      bus.ifid_we_o     = 1'b1;
      bus.idex_we_o     = 1'b1;
      bus.exmem_we_o    = 1'b1;
      bus.ifid_flush_o  = 1'b0;
      bus.idex_flush_o  = 1'b0;
      bus.exmem_flush_o = 1'b0;
      bus.memwb_flush_o = 1'b0;
      unique case (act)
         A_FREEZE: begin
            bus.pc_we_o       = 1'b0;
            bus.ifid_we_o     = 1'b0;
            bus.idex_we_o     = 1'b0;
            bus.exmem_we_o    = 1'b0;
            bus.memwb_flush_o = 1'b1;
         end
         A_BRANCH: begin
            bus.ifid_flush_o  = 1'b1;
            bus.idex_flush_o  = 1'b1;
            bus.exmem_flush_o = 1'b1;
         end
         A_LU: begin
            bus.pc_we_o      = 1'b0;
            bus.ifid_we_o    = 1'b0;
            bus.idex_flush_o = 1'b1;
         end
         A_JUMP:  bus.ifid_flush_o = 1'b1;
         default: ;
      endcase
      // Reset holds every pipeline register in its bubble state, not merely stalled.
      if (rst_i) begin
         bus.pc_we_o       = 1'b0;
         bus.ifid_we_o     = 1'b0;
         bus.idex_we_o     = 1'b0;
         bus.exmem_we_o    = 1'b0;
         bus.ifid_flush_o  = 1'b1;
         bus.idex_flush_o  = 1'b1;
         bus.exmem_flush_o = 1'b1;
         bus.memwb_flush_o = 1'b1;
      end
   end

   assign bus.state_o     = state_q;
   assign bus.timeout_o   = timeout_q;
   assign bus.stall_cnt_o = stall_q;
   assign bus.flush_cnt_o = flush_q;
endmodule
